// File: rtl/imem_fetch_ctrl_if.sv
// Fetch, response, loader and byte-memory signals of imem_fetch_ctrl.
// Ports (slave = controller view):
//   fetch_req_i/fetch_pc_i/fetch_ready_o   : fetch request handshake
//   instr_valid_o/instr_ready_i/instr_o/imem_error_o : instruction response
//   load_req_i/load_addr_i/load_data_i/load_ack_o    : byte loader
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i      : byte memory port
interface imem_fetch_ctrl_if #(
  parameter int unsigned AW = 10
) ();
  logic          fetch_req_i;
  logic [63:0]   fetch_pc_i;
  logic          fetch_ready_o;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_o;
  logic          imem_error_o;
  logic          load_req_i;
  logic [AW-1:0] load_addr_i;
  logic [7:0]    load_data_i;
  logic          load_ack_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i;

  // Controller side.
  modport slave (
    input  fetch_req_i, fetch_pc_i, instr_ready_i,
           load_req_i, load_addr_i, load_data_i, mem_rdata_i,
    output fetch_ready_o, instr_valid_o, instr_o, imem_error_o,
           load_ack_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

  // Environment side (fetch unit, consumer, loader, memory).
  modport master (
    output fetch_req_i, fetch_pc_i, instr_ready_i,
           load_req_i, load_addr_i, load_data_i, mem_rdata_i,
    input  fetch_ready_o, instr_valid_o, instr_o, imem_error_o,
           load_ack_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller over a byte-wide instruction memory.
// Assembles a 32-bit little-endian word from four sequential byte reads,
// flags out-of-range fetches, and lets a loader write bytes while idle.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : imem_fetch_ctrl_if.slave (fetch, response, loader, memory)
module imem_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  imem_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, RESP, ERR} state_t;

  localparam int unsigned CW       = 3;
  // Counter values 0..3 issue byte addresses; value 4 is the final capture cycle.
  localparam logic [CW-1:0] LAST_CNT = CW'(4);
  localparam logic [63:0]   LAST_PC  = 64'(MEM_BYTES - 4);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   word_q;
  logic          accept_c;
  logic          in_range_c;
  logic [1:0]    byte_idx_c;

  // Loader wins over fetch in IDLE.
  assign accept_c   = (state_q == IDLE) && bus.fetch_req_i && !bus.load_req_i;
  // Full 64-bit compare so any bit above AW forces the error path.
  assign in_range_c = (bus.fetch_pc_i <= LAST_PC);
  // Byte returned this cycle belongs to the address issued one cycle earlier.
  assign byte_idx_c = 2'(cnt_q - CW'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = in_range_c ? FETCH : ERR;
        end
      end
      FETCH: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
        end
      end
      RESP, ERR: begin
        if (bus.instr_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch datapath: pc latch, byte counter, word assembly.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      pc_q   <= '0;
      word_q <= '0;
    end else begin
      if (accept_c) begin
        pc_q  <= bus.fetch_pc_i[AW-1:0];
        cnt_q <= '0;
      end else if (state_q == FETCH) begin
        cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        if (cnt_q != '0) begin
          word_q[{byte_idx_c, 3'b000} +: 8] <= bus.mem_rdata_i;
        end
      end
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    bus.fetch_ready_o = 1'b0;
    bus.load_ack_o    = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;
    bus.instr_valid_o = 1'b0;
    bus.instr_o       = 32'h0;
    bus.imem_error_o  = 1'b0;
    if (rst_n_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.load_req_i) begin
            bus.mem_we_o    = 1'b1;
            bus.mem_addr_o  = bus.load_addr_i;
            bus.mem_wdata_o = bus.load_data_i;
            bus.load_ack_o  = 1'b1;
          end
          bus.fetch_ready_o = bus.fetch_req_i && !bus.load_req_i;
        end
        FETCH: begin
          if (cnt_q != LAST_CNT) begin
            bus.mem_addr_o = pc_q + AW'(cnt_q);
          end
        end
        RESP: begin
          bus.instr_valid_o = 1'b1;
          bus.instr_o       = word_q;
        end
        ERR: begin
          bus.instr_valid_o = 1'b1;
          bus.imem_error_o  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
